// File: rtl/counter_scan.sv
// WIDTH-bit up-counter whose register doubles as a serial scan chain (scan_in -> bit 0, MSB -> scan_out).
// Define COUNTER_SCAN_TC_EN to add the combinational terminal-count output tc.
module counter_scan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic [WIDTH-1:0] count_out,
`ifdef COUNTER_SCAN_TC_EN
  output logic             tc,
`endif
  output logic             scan_out
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Scan shifting takes priority over counting; with neither, the value holds.
  always_comb begin
    cnt_d = cnt_q;
    if (scan_en) begin
      cnt_d = {cnt_q[WIDTH-2:0], scan_in};
    end else if (enable) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_out = cnt_q;
  assign scan_out  = cnt_q[WIDTH-1];

`ifdef COUNTER_SCAN_TC_EN
  // Terminal count is suppressed while the register is acting as a scan chain.
  assign tc = (&cnt_q) & ~scan_en;
`endif

endmodule

// File: tb/tb_counter_scan.sv
// Self-checking bench for counter_scan (WIDTH=8): directed vector table, hand-written
// corner sequences and a randomized run against an arithmetic reference model.
module tb_counter_scan;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             scan_en;
  logic             scan_in;
  logic [WIDTH-1:0] count_out;
  logic             scan_out;
`ifdef COUNTER_SCAN_TC_EN
  logic             tc;
`endif

  int errors;
  int checks;

  counter_scan #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .count_out (count_out),
`ifdef COUNTER_SCAN_TC_EN
    .tc        (tc),
`endif
    .scan_out  (scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       se;
    logic       si;
    logic [7:0] exp_cnt;  // count_out just after the edge
    logic       exp_so;   // scan_out just before the edge
  } vec_t;

  vec_t vecs[33];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Load a byte through the scan chain, MSB first.
  task automatic scan_load(input logic [7:0] val);
    for (int i = 7; i >= 0; i--) begin
      scan_en = 1'b1;
      enable  = 1'b0;
      scan_in = val[i];
      edge_wait();
    end
    check("scan_load", count_out, val);
  endtask

  initial begin
    logic [7:0] shift_bits;
    logic [7:0] shift_so;
    logic [7:0] m;
    logic       r_rst, r_en, r_se, r_si;

    errors  = 0;
    checks  = 0;
    rst     = 1'b0;
    enable  = 1'b1;
    scan_en = 1'b0;
    scan_in = 1'b0;

    // Reset held with enable asserted: nothing may count.
    #1;
    check("reset_cnt", count_out, 8'h00);
    check("reset_so", scan_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      check("reset_hold_cnt", count_out, 8'h00);
    end
`ifdef COUNTER_SCAN_TC_EN
    check("reset_tc", tc, 1'b0);
`endif
    rst = 1'b1;

    // Vector table: 20 increments, 8 shifts to 0xB3, 5 holds.
    shift_bits = 8'b1011_0011;
    shift_so   = 8'b0001_0100;
    for (int i = 0; i < 20; i++) begin
      vecs[i] = '{en: 1'b1, se: 1'b0, si: 1'b1, exp_cnt: 8'(i + 1), exp_so: 1'b0};
    end
    for (int i = 0; i < 8; i++) begin
      vecs[20 + i].en     = 1'b0;
      vecs[20 + i].se     = 1'b1;
      vecs[20 + i].si     = shift_bits[7 - i];
      vecs[20 + i].exp_so = shift_so[7 - i];
      vecs[20 + i].exp_cnt = (i == 7) ? 8'hB3 : 8'h00;
    end
    vecs[20].exp_cnt = 8'h29;
    vecs[21].exp_cnt = 8'h52;
    vecs[22].exp_cnt = 8'hA5;
    vecs[23].exp_cnt = 8'h4B;
    vecs[24].exp_cnt = 8'h96;
    vecs[25].exp_cnt = 8'h2C;
    vecs[26].exp_cnt = 8'h59;
    for (int i = 28; i < 33; i++) begin
      vecs[i] = '{en: 1'b0, se: 1'b0, si: 1'b1, exp_cnt: 8'hB3, exp_so: 1'b1};
    end

    for (int i = 0; i < 33; i++) begin
      enable  = vecs[i].en;
      scan_en = vecs[i].se;
      scan_in = vecs[i].si;
      #1;
      check($sformatf("vec%0d_so", i), scan_out, vecs[i].exp_so);
      edge_wait();
      check($sformatf("vec%0d_cnt", i), count_out, vecs[i].exp_cnt);
    end

    // Wrap from 0xFE through 0xFF to 0x00.
    scan_load(8'hFE);
    scan_en = 1'b0;
    enable  = 1'b1;
    #1;
`ifdef COUNTER_SCAN_TC_EN
    check("wrap_tc_fe", tc, 1'b0);
`endif
    edge_wait();
    check("wrap_ff", count_out, 8'hFF);
`ifdef COUNTER_SCAN_TC_EN
    check("wrap_tc_ff", tc, 1'b1);
    scan_en = 1'b1;
    #1;
    check("wrap_tc_scan", tc, 1'b0);
    scan_en = 1'b0;
    #1;
`endif
    edge_wait();
    check("wrap_00", count_out, 8'h00);
`ifdef COUNTER_SCAN_TC_EN
    check("wrap_tc_00", tc, 1'b0);
`endif

    // enable together with scan_en must shift, not count.
    scan_load(8'h01);
    enable  = 1'b1;
    scan_en = 1'b1;
    scan_in = 1'b0;
    edge_wait();
    check("both_02", count_out, 8'h02);
    edge_wait();
    check("both_04", count_out, 8'h04);

    // Asynchronous reset mid-shift: clears without a clock edge, edges ignored while low.
    scan_in = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_cnt", count_out, 8'h00);
    check("async_rst_so", scan_out, 1'b0);
    edge_wait();
    check("rst_low_edge", count_out, 8'h00);
    rst = 1'b1;
    edge_wait();
    check("rst_release_shift", count_out, 8'h01);

    // Randomized run against an arithmetic model.
    m = 8'h01;
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 24) != 0);
      r_en  = 1'($urandom);
      r_se  = ($urandom_range(0, 3) == 0);
      r_si  = 1'($urandom);
      rst     = r_rst;
      enable  = r_en;
      scan_en = r_se;
      scan_in = r_si;
      if (!r_rst) m = 8'h00;
      #1;
      check("rand_so", scan_out, m[7]);
`ifdef COUNTER_SCAN_TC_EN
      check("rand_tc", tc, (m == 8'hFF) && !r_se);
`endif
      if (r_rst) begin
        if (r_se)      m = 8'((int'(m) * 2 + int'(r_si)) % 256);
        else if (r_en) m = 8'((int'(m) + 1) % 256);
      end
      edge_wait();
      check("rand_cnt", count_out, m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
